// File: rtl/sobel_line_buffer.sv
// rtl/sobel_line_buffer.sv - RAM-backed raster line buffer presenting a vertical column of ROWS taps
module sobel_line_buffer #(
  parameter int DATA_W   = 8,
  parameter int LINE_LEN = 256,
  parameter int ROWS     = 3
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         Enable,
  input  logic                         SoF,
  input  logic [DATA_W-1:0]            DataIn,
  output logic [ROWS*DATA_W-1:0]       DataOut,
  output logic                         OutValid,
  output logic                         WindowValid,
  output logic                         LastCol,
  output logic [$clog2(LINE_LEN)-1:0]  ColIdx
);

  localparam int AW = $clog2(LINE_LEN);
  localparam int FW = $clog2(ROWS);
  localparam logic [AW-1:0] LAST_COL = AW'(LINE_LEN - 1);
  localparam logic [FW-1:0] FULL     = FW'(ROWS - 1);

  logic [AW-1:0]     ptr;
  logic [AW-1:0]     addr;
  logic [FW-1:0]     fill;
  logic [FW-1:0]     fillEff;
  logic [FW-1:0]     fillNext;
  logic              atLast;
  logic [DATA_W-1:0] tap0;
  logic [ROWS-1:1]   tapLive;

  logic [DATA_W-1:0] lineMem [ROWS-1][LINE_LEN];
  logic [DATA_W-1:0] rdData  [ROWS-1];

  // SoF forces column 0 and an empty fill for the pixel it marks.
  always_comb begin
    addr     = SoF ? '0 : ptr;
    fillEff  = SoF ? '0 : fill;
    atLast   = (addr == LAST_COL);
    fillNext = fillEff;
    if (atLast && (fillEff != FULL)) fillNext = fillEff + FW'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr         <= '0;
      fill        <= '0;
      tap0        <= '0;
      tapLive     <= '0;
      OutValid    <= 1'b0;
      WindowValid <= 1'b0;
      LastCol     <= 1'b0;
      ColIdx      <= '0;
    end else begin
      OutValid <= Enable;
      if (Enable) begin
        ptr         <= atLast ? '0 : addr + AW'(1);
        fill        <= fillNext;
        tap0        <= DataIn;
        WindowValid <= (fillEff == FULL);
        ColIdx      <= addr;
        LastCol     <= atLast;
        for (int k = 1; k < ROWS; k++) tapLive[k] <= (fillEff >= FW'(k));
      end
    end
  end

  // Read-before-write: each memory passes its old word down to the next line.
  always_ff @(posedge CLK) begin
    if (Enable) begin
      lineMem[0][addr] <= DataIn;
      for (int j = 1; j < ROWS - 1; j++) lineMem[j][addr] <= lineMem[j-1][addr];
      for (int j = 0; j < ROWS - 1; j++) rdData[j] <= lineMem[j][addr];
    end
  end

  // Stale memory words are hidden by the per-tap live flags.
  always_comb begin
    DataOut = '0;
    DataOut[0 +: DATA_W] = tap0;
    for (int k = 1; k < ROWS; k++)
      DataOut[k*DATA_W +: DATA_W] = tapLive[k] ? rdData[k-1] : '0;
  end

endmodule

// File: tb/tb_sobel_line_buffer.sv
// tb/tb_sobel_line_buffer.sv - directed self-checking bench for sobel_line_buffer
module tb_sobel_line_buffer;

  logic        clk = 1'b0;
  logic        rstN;
  logic        enable;
  logic        sof;
  logic [7:0]  dataIn;

  logic [23:0] dataOut;
  logic        outValid, windowValid, lastCol;
  logic [1:0]  colIdx;

  logic [23:0] dataOut5;
  logic        outValid5, windowValid5, lastCol5;
  logic [2:0]  colIdx5;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sobel_line_buffer #(.DATA_W(8), .LINE_LEN(4), .ROWS(3)) dut (
    .CLK(clk), .RST_N(rstN), .Enable(enable), .SoF(sof), .DataIn(dataIn),
    .DataOut(dataOut), .OutValid(outValid), .WindowValid(windowValid),
    .LastCol(lastCol), .ColIdx(colIdx)
  );

  sobel_line_buffer #(.DATA_W(8), .LINE_LEN(5), .ROWS(3)) dut5 (
    .CLK(clk), .RST_N(rstN), .Enable(enable), .SoF(sof), .DataIn(dataIn),
    .DataOut(dataOut5), .OutValid(outValid5), .WindowValid(windowValid5),
    .LastCol(lastCol5), .ColIdx(colIdx5)
  );

  task automatic step(input logic en, input logic s, input logic [7:0] d);
    enable = en;
    sof    = s;
    dataIn = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b0; enable = 1'b0; sof = 1'b0; dataIn = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dataOut !== 24'h0) begin failures++; $display("FAIL reset_dataout got=%h exp=%h", dataOut, 24'h0); end
    checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL reset_outvalid got=%b exp=0", outValid); end
    checks++; if (windowValid !== 1'b0) begin failures++; $display("FAIL reset_windowvalid got=%b exp=0", windowValid); end
    checks++; if (lastCol !== 1'b0) begin failures++; $display("FAIL reset_lastcol got=%b exp=0", lastCol); end
    checks++; if (colIdx !== 2'd0) begin failures++; $display("FAIL reset_colidx got=%0d exp=0", colIdx); end
    rstN = 1'b1;
  endtask

  task automatic test_stream();
    logic [7:0]  t1, t2;
    logic [23:0] exp;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, i == 0, 8'(i));
      t1  = (i >= 4) ? 8'(i - 4) : 8'd0;
      t2  = (i >= 8) ? 8'(i - 8) : 8'd0;
      exp = {t2, t1, 8'(i)};
      checks++; if (dataOut !== exp) begin failures++; $display("FAIL stream_data i=%0d got=%h exp=%h", i, dataOut, exp); end
      checks++; if (outValid !== 1'b1) begin failures++; $display("FAIL stream_outvalid i=%0d got=%b exp=1", i, outValid); end
      checks++; if (colIdx !== 2'(i % 4)) begin failures++; $display("FAIL stream_colidx i=%0d got=%0d exp=%0d", i, colIdx, i % 4); end
      checks++; if (windowValid !== (i >= 8)) begin failures++; $display("FAIL stream_windowvalid i=%0d got=%b exp=%b", i, windowValid, i >= 8); end
      if (i == 4) begin
        checks++; if (dataOut !== {8'd0, 8'd0, 8'd4}) begin failures++; $display("FAIL stream_in4 got=%h exp=%h", dataOut, {8'd0, 8'd0, 8'd4}); end
      end
      if (i == 9) begin
        checks++; if (dataOut !== {8'd1, 8'd5, 8'd9} || colIdx !== 2'd1 || windowValid !== 1'b1) begin
          failures++; $display("FAIL stream_in9 got=%h col=%0d wv=%b exp=010509 col=1 wv=1", dataOut, colIdx, windowValid);
        end
      end
    end
  endtask

  task automatic test_enable_gaps();
    logic [23:0] exp, held;
    logic [1:0]  heldCol;
    logic        heldWv, heldLast;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, i == 0, 8'(i));
      exp = {((i >= 8) ? 8'(i - 8) : 8'd0), ((i >= 4) ? 8'(i - 4) : 8'd0), 8'(i)};
      checks++; if (dataOut !== exp || outValid !== 1'b1) begin
        failures++; $display("FAIL gaps_data i=%0d got=%h v=%b exp=%h v=1", i, dataOut, outValid, exp);
      end
      held = exp; heldCol = 2'(i % 4); heldWv = (i >= 8); heldLast = (i % 4 == 3);
      step(1'b0, 1'b1, 8'hA5);
      checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL gaps_idle_valid i=%0d got=%b exp=0", i, outValid); end
      checks++; if (dataOut !== held || colIdx !== heldCol || windowValid !== heldWv || lastCol !== heldLast) begin
        failures++; $display("FAIL gaps_hold i=%0d got=%h/%0d/%b/%b exp=%h/%0d/%b/%b", i, dataOut, colIdx, windowValid, lastCol, held, heldCol, heldWv, heldLast);
      end
    end
  endtask

  task automatic test_sof_restart();
    step(1'b1, 1'b1, 8'd100);
    checks++; if (dataOut !== {8'd0, 8'd0, 8'd100} || colIdx !== 2'd0 || windowValid !== 1'b0) begin
      failures++; $display("FAIL sof_first got=%h col=%0d wv=%b exp=000064 col=0 wv=0", dataOut, colIdx, windowValid);
    end
    for (int i = 101; i <= 103; i++) step(1'b1, 1'b0, 8'(i));
    checks++; if (colIdx !== 2'd3 || lastCol !== 1'b1) begin
      failures++; $display("FAIL sof_col3 got col=%0d last=%b exp col=3 last=1", colIdx, lastCol);
    end
    step(1'b1, 1'b0, 8'd104);
    checks++; if (dataOut !== {8'd0, 8'd100, 8'd104} || colIdx !== 2'd0) begin
      failures++; $display("FAIL sof_104 got=%h col=%0d exp=006468 col=0", dataOut, colIdx);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i <= 6; i++) step(1'b1, i == 0, 8'(i));
    #2 rstN = 1'b0;
    #1;
    checks++; if (dataOut !== 24'h0 || outValid !== 1'b0 || windowValid !== 1'b0 || lastCol !== 1'b0 || colIdx !== 2'd0) begin
      failures++; $display("FAIL async_reset got=%h/%b/%b/%b/%0d exp all zero", dataOut, outValid, windowValid, lastCol, colIdx);
    end
    enable = 1'b0;
    @(posedge clk);
    #1 rstN = 1'b1;
    step(1'b1, 1'b0, 8'd50);
    checks++; if (dataOut !== {8'd0, 8'd0, 8'd50} || colIdx !== 2'd0 || outValid !== 1'b1) begin
      failures++; $display("FAIL post_reset_50 got=%h col=%0d v=%b exp=000032 col=0 v=1", dataOut, colIdx, outValid);
    end
  endtask

  task automatic test_lastcol();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i == 0, 8'(i));
      checks++; if (lastCol !== (i % 4 == 3) || colIdx !== 2'(i % 4)) begin
        failures++; $display("FAIL lastcol i=%0d got last=%b col=%0d exp last=%b col=%0d", i, lastCol, colIdx, i % 4 == 3, i % 4);
      end
    end
  endtask

  task automatic test_line_len5();
    for (int i = 0; i < 15; i++) begin
      step(1'b1, i == 0, 8'(i));
      if (i == 12) begin
        checks++; if (dataOut5 !== {8'd2, 8'd7, 8'd12} || colIdx5 !== 3'd2) begin
          failures++; $display("FAIL len5_in12 got=%h col=%0d exp=02070c col=2", dataOut5, colIdx5);
        end
      end
      if (i == 14) begin
        checks++; if (lastCol5 !== 1'b1 || colIdx5 !== 3'd4 || windowValid5 !== 1'b1) begin
          failures++; $display("FAIL len5_in14 got last=%b col=%0d wv=%b exp last=1 col=4 wv=1", lastCol5, colIdx5, windowValid5);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_enable_gaps();
    test_sof_restart();
    test_async_reset();
    test_lastcol();
    test_line_len5();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
